// File: rtl/fpu_issue_sequencer_pkg.sv
// Shared definitions for the FPU issue sequencer: FPU operation codes,
// sequencer states and the default watchdog limit.
package fpu_issue_sequencer_pkg;

  typedef enum logic [1:0] {
    FPU_ADD  = 2'b00,
    FPU_SUB  = 2'b01,
    FPU_MUL  = 2'b10,
    FPU_SQRT = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10,
    ST_FLUSH = 2'b11
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // MUL and SQRT run internal state machines that need a flush cycle afterwards.
  function automatic logic is_multicycle(input fpu_op_e op);
    return (op == FPU_MUL) || (op == FPU_SQRT);
  endfunction

endpackage

// File: rtl/fpu_issue_sequencer_if.sv
// Request, FPU and response signals of the issue sequencer.
// master = the sequencer itself, slave = execute stage / FPU / writeback.
interface fpu_issue_sequencer_if
  import fpu_issue_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RD_WIDTH = 5
);
  logic                req_valid;
  logic                req_ready;
  fpu_op_e             req_op;
  logic [WIDTH-1:0]    req_operand_1;
  logic [WIDTH-1:0]    req_operand_2;
  logic [RD_WIDTH-1:0] req_rd;

  logic [WIDTH-1:0]    fpu_operand_1;
  logic [WIDTH-1:0]    fpu_operand_2;
  fpu_op_e             fpu_operation;
  logic [WIDTH-1:0]    fpu_result;
  logic                fpu_ready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_result;
  logic [RD_WIDTH-1:0] rsp_rd;
  logic                rsp_error;

  logic                busy;

  modport master (
    input  req_valid, req_op, req_operand_1, req_operand_2, req_rd,
    output req_ready,
    output fpu_operand_1, fpu_operand_2, fpu_operation,
    input  fpu_result, fpu_ready,
    output rsp_valid, rsp_result, rsp_rd, rsp_error,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output req_valid, req_op, req_operand_1, req_operand_2, req_rd,
    input  req_ready,
    input  fpu_operand_1, fpu_operand_2, fpu_operation,
    output fpu_result, fpu_ready,
    input  rsp_valid, rsp_result, rsp_rd, rsp_error,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/fpu_issue_sequencer_wait_counter.sv
// fpu_wait_counter: clearable saturating up-counter; o_expired marks the
// LIMIT-th enabled cycle since the last clear.
module fpu_wait_counter
  import fpu_issue_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned   CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Initiator side of the fixed-point unit: issues one request, waits for the FPU,
// returns the result, flushes after MUL/SQRT. Optional watchdog: FPU_TIMEOUT_EN.
module fpu_issue_sequencer
  import fpu_issue_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned RD_WIDTH       = 5,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  fpu_issue_sequencer_if.master bus
);

  seq_state_e          r_state;
  fpu_op_e             r_op;
  fpu_op_e             r_fpu_operation;
  logic [WIDTH-1:0]    r_operand_1;
  logic [WIDTH-1:0]    r_operand_2;
  logic [WIDTH-1:0]    r_rsp_result;
  logic [RD_WIDTH-1:0] r_rd;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_busy;
  logic                r_first_issue;

  logic w_accept;
  logic w_fpu_done;
  logic w_timeout;
  logic w_timed_out;

  assign w_accept   = (r_state == ST_IDLE) && bus.req_valid && r_req_ready;
  // A multi-cycle unit may still show ready from its previous operation.
  assign w_fpu_done = bus.fpu_ready && !(r_first_issue && is_multicycle(r_op));

`ifdef FPU_TIMEOUT_EN
  logic r_rsp_error;
  logic r_timed_out;

  fpu_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_enable  (r_state == ST_ISSUE),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_error <= 1'b0;
      r_timed_out <= 1'b0;
    end else if (w_accept) begin
      r_rsp_error <= 1'b0;
      r_timed_out <= 1'b0;
    end else if ((r_state == ST_ISSUE) && !w_fpu_done && w_timeout) begin
      r_rsp_error <= 1'b1;
      r_timed_out <= 1'b1;
    end
  end

  assign bus.rsp_error = r_rsp_error;
  assign w_timed_out   = r_timed_out;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign w_timed_out      = 1'b0;
  assign bus.rsp_error    = 1'b0;
`endif

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking = here would leak new values into later lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_op            <= FPU_ADD;
      r_fpu_operation <= FPU_ADD;
      r_operand_1     <= '0;
      r_operand_2     <= '0;
      r_rsp_result    <= '0;
      r_rd            <= '0;
      r_req_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_first_issue   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op            <= bus.req_op;
            r_fpu_operation <= bus.req_op;
            r_operand_1     <= bus.req_operand_1;
            r_operand_2     <= bus.req_operand_2;
            r_rd            <= bus.req_rd;
            r_first_issue   <= 1'b1;
            r_req_ready     <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_first_issue <= 1'b0;
          if (w_fpu_done) begin
            r_rsp_result <= bus.fpu_result;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid     <= 1'b0;
            r_fpu_operation <= FPU_ADD;
            if (is_multicycle(r_op) || w_timed_out) begin
              r_state <= ST_FLUSH;
            end else begin
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.fpu_operand_1 = r_operand_1;
  assign bus.fpu_operand_2 = r_operand_2;
  assign bus.fpu_operation = r_fpu_operation;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_rd        = r_rd;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer with a small Q.10 fixed-point FPU model
// (MUL latency 3, SQRT latency 5, stale-ready injection, stall for the watchdog).
module tb_fpu_issue_sequencer;
  import fpu_issue_sequencer_pkg::*;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned RD_WIDTH = 5;
`ifdef FPU_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 8;
`else
  localparam int unsigned TO_CYCLES = 64;
`endif

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fpu_issue_sequencer_if #(.WIDTH(WIDTH), .RD_WIDTH(RD_WIDTH)) bus ();

  fpu_issue_sequencer #(
    .WIDTH          (WIDTH),
    .RD_WIDTH       (RD_WIDTH),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FPU model ----------------
  logic [3:0]  m_cnt;
  logic        m_force_ready;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_exact;
  logic [3:0]  m_lat;

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      logic [31:0] t;
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= v) r = t;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= '0;
    else if (is_multicycle(bus.fpu_operation)) m_cnt <= (m_cnt == 4'hF) ? m_cnt : m_cnt + 4'd1;
    else m_cnt <= '0;
  end

  always_comb begin
    logic [63:0] prod;
    prod    = 64'(bus.fpu_operand_1) * 64'(bus.fpu_operand_2);
    m_exact = '0;
    m_lat   = '0;
    case (bus.fpu_operation)
      FPU_ADD:  m_exact = bus.fpu_operand_1 + bus.fpu_operand_2;
      FPU_SUB:  m_exact = bus.fpu_operand_1 - bus.fpu_operand_2;
      FPU_MUL:  begin m_exact = prod[41:10]; m_lat = 4'd3; end
      FPU_SQRT: begin m_exact = isqrt({22'd0, bus.fpu_operand_1, 10'd0}); m_lat = 4'd5; end
      default:  m_exact = '0;
    endcase
    m_done         = (m_cnt >= m_lat);
    bus.fpu_ready  = !m_stall && (m_done || m_force_ready);
    bus.fpu_result = m_done ? m_exact : 32'hBAD0_BAD0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input fpu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.req_op        = op;
    bus.req_operand_1 = a;
    bus.req_operand_2 = b;
    bus.req_rd        = rd;
    bus.req_valid     = 1'b1;
    tick();
    bus.req_valid     = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; checks that the FPU saw exp_op the whole time.
  task automatic wait_rsp(input string tag, input int limit, input fpu_op_e exp_op,
                          output int cycles);
    logic op_ok;
    cycles = 0;
    op_ok  = 1'b1;
    while (!bus.rsp_valid && cycles < limit) begin
      if (bus.fpu_operation !== exp_op) op_ok = 1'b0;
      tick();
      cycles++;
    end
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    check({tag, "_op_held"}, op_ok, 1'b1);
  endtask

  int cyc;

  initial begin
    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_op        = FPU_ADD;
    bus.req_operand_1 = '0;
    bus.req_operand_2 = '0;
    bus.req_rd        = '0;
    bus.rsp_ready     = 1'b0;
    m_force_ready     = 1'b0;
    m_stall           = 1'b0;

    // Reset state
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_error", bus.rsp_error, 1'b0);
    check("rst_rsp", {bus.rsp_result, bus.rsp_rd}, 37'd0);
    check("rst_fpu_ops", {bus.fpu_operand_1, bus.fpu_operand_2}, 64'd0);
    check("rst_fpu_operation", bus.fpu_operation, FPU_ADD);
    check("rst_busy", bus.busy, 1'b0);
    #10 reset = 1'b0;

    // ADD, result one edge after accept
    bus.rsp_ready = 1'b1;
    issue(FPU_ADD, 32'h400, 32'h800, 5'd3);
    check("add_req_ready", bus.req_ready, 1'b0);
    check("add_busy", bus.busy, 1'b1);
    check("add_fpu_ops", {bus.fpu_operand_1, bus.fpu_operand_2}, {32'h400, 32'h800});
    wait_rsp("add", 10, FPU_ADD, cyc);
    check("add_latency", cyc, 1);
    check("add_result", bus.rsp_result, 32'hC00);
    check("add_rd", bus.rsp_rd, 5'd3);
    check("add_error", bus.rsp_error, 1'b0);
    tick();
    check("add_done", {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);

    // MUL, then a single flush cycle
    bus.rsp_ready = 1'b0;
    issue(FPU_MUL, 32'h600, 32'h800, 5'd5);
    wait_rsp("mul", 20, FPU_MUL, cyc);
    check("mul_latency", cyc, 4);
    check("mul_result", bus.rsp_result, 32'hC00);
    check("mul_rd", bus.rsp_rd, 5'd5);
    bus.rsp_ready = 1'b1;
    tick();
    check("mul_flush_op", bus.fpu_operation, FPU_ADD);
    check("mul_flush_hs", {bus.req_ready, bus.busy, bus.rsp_valid}, 3'b010);
    tick();
    check("mul_idle", {bus.req_ready, bus.busy}, 2'b10);

    // SQRT, then a second SQRT facing a stale ready in its first ISSUE cycle
    issue(FPU_SQRT, 32'h1000, 32'h0, 5'd6);
    wait_rsp("sqrt1", 20, FPU_SQRT, cyc);
    check("sqrt1_latency", cyc, 6);
    check("sqrt1_result", bus.rsp_result, 32'h800);
    tick();
    check("sqrt1_flush_op", bus.fpu_operation, FPU_ADD);
    tick();
    m_force_ready = 1'b1;
    issue(FPU_SQRT, 32'h1000, 32'h0, 5'd7);
    tick();
    m_force_ready = 1'b0;
    check("sqrt2_guard", bus.rsp_valid, 1'b0);
    wait_rsp("sqrt2", 20, FPU_SQRT, cyc);
    check("sqrt2_latency", cyc, 5);
    check("sqrt2_result", bus.rsp_result, 32'h800);
    check("sqrt2_rd", bus.rsp_rd, 5'd7);
    tick();
    tick();

    // Backpressure: RESP held, new request not taken until the response leaves
    bus.rsp_ready = 1'b0;
    issue(FPU_SUB, 32'h1400, 32'h400, 5'd8);
    wait_rsp("sub", 10, FPU_SUB, cyc);
    check("sub_latency", cyc, 1);
    bus.req_op        = FPU_ADD;
    bus.req_operand_1 = 32'h100;
    bus.req_operand_2 = 32'h200;
    bus.req_rd        = 5'd9;
    bus.req_valid     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp", {bus.rsp_valid, bus.rsp_result, bus.rsp_rd}, {1'b1, 32'h1000, 5'd8});
      check("bp_fpu", {bus.req_ready, bus.fpu_operand_1, bus.fpu_operation},
            {1'b0, 32'h1400, FPU_SUB});
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_release", {bus.rsp_valid, bus.req_ready}, 2'b01);
    tick();
    bus.req_valid = 1'b0;
    check("bp_accept", {bus.req_ready, bus.fpu_operand_1}, {1'b0, 32'h100});
    wait_rsp("bp_add", 10, FPU_ADD, cyc);
    check("bp_add_result", {bus.rsp_result, bus.rsp_rd}, {32'h300, 5'd9});
    tick();

    // Asynchronous reset in the third ISSUE cycle of a MUL
    issue(FPU_MUL, 32'h600, 32'h800, 5'd4);
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    check("mid_rst_hs", {bus.req_ready, bus.rsp_valid, bus.busy}, 3'b100);
    check("mid_rst_op", bus.fpu_operation, FPU_ADD);
    check("mid_rst_fpu_op1", bus.fpu_operand_1, 32'h0);
    #2 reset = 1'b0;
    issue(FPU_ADD, 32'h400, 32'h400, 5'd1);
    wait_rsp("post_rst", 10, FPU_ADD, cyc);
    check("post_rst_result", {bus.rsp_result, bus.rsp_rd}, {32'h800, 5'd1});
    tick();

`ifdef FPU_TIMEOUT_EN
    // Watchdog: FPU never answers
    m_stall = 1'b1;
    issue(FPU_MUL, 32'h600, 32'h800, 5'd2);
    wait_rsp("to", 20, FPU_MUL, cyc);
    check("to_latency", cyc, 8);
    check("to_error", bus.rsp_error, 1'b1);
    check("to_result", bus.rsp_result, 32'h0);
    tick();
    m_stall = 1'b0;
    check("to_flush", {bus.fpu_operation, bus.req_ready}, {FPU_ADD, 1'b0});
    tick();
    check("to_error_held", bus.rsp_error, 1'b1);
    issue(FPU_ADD, 32'h400, 32'h800, 5'd3);
    check("to_error_clear", bus.rsp_error, 1'b0);
    wait_rsp("to_next", 10, FPU_ADD, cyc);
    check("to_next_result", bus.rsp_result, 32'hC00);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
